// File: rtl/pe_grid_sched.sv
// Sequencing controller for the PE grid: loads weight rows, streams image
// vectors with ready/valid flow control, then tracks psum results until done.
module pe_grid_sched #(
  parameter int ROWS = 12,
  parameter int COLS = 14,
  parameter int DW   = 16,
  parameter int PW   = 32,
  parameter int LW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LW-1:0]        cfg_len,
  input  logic [3:0]           cfg_lat,
  output logic                 busy,
  output logic                 done,
  output logic                 w_req,
  output logic [3:0]           w_addr,
  input  logic                 w_valid,
  input  logic [COLS*DW-1:0]   w_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [COLS*DW-1:0]   x_data,
  input  logic [COLS-1:0]      x_mask,
  output logic [COLS*DW-1:0]   g_weight,
  output logic [3:0]           g_tag_row,
  output logic                 g_valid_y,
  output logic [COLS*DW-1:0]   g_image,
  output logic [COLS-1:0]      g_valid_x,
  input  logic [COLS*PW-1:0]   g_psum,
  output logic                 res_valid,
  output logic [COLS*PW-1:0]   res_data
);

  localparam int DLN = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           row_q, row_d;
  logic [LW-1:0]        count_q, count_d;
  logic [LW-1:0]        len_q, len_d;
  logic [3:0]           lat_q, lat_d;
  logic [DLN-1:0]       dl_q, dl_d;
  logic [COLS*DW-1:0]   gw_q, gw_d;
  logic [3:0]           tag_q, tag_d;
  logic                 vy_q, vy_d;
  logic [COLS*DW-1:0]   gi_q, gi_d;
  logic [COLS-1:0]      vx_q, vx_d;

  logic [LW-1:0]        count_inc;
  logic [DLN-1:0]       below_lat;

  assign count_inc = count_q + LW'(1);
  // Delay-line stages strictly younger than the psum tap.
  assign below_lat = (DLN'(1) << lat_q) - DLN'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    count_d = count_q;
    len_d   = len_q;
    lat_d   = lat_q;
    dl_d    = dl_q;
    gw_d    = gw_q;
    tag_d   = tag_q;
    vy_d    = 1'b0;
    gi_d    = gi_q;
    vx_d    = '0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    w_req   = 1'b0;
    w_addr  = '0;
    x_ready = 1'b0;

    if (state_q != S_IDLE) begin
      dl_d = {dl_q[DLN-2:0], 1'b0};
    end

    case (state_q)
      S_IDLE: begin
        dl_d = '0;
        if (start) begin
          if (cfg_len != '0) begin
            len_d   = cfg_len;
            lat_d   = cfg_lat;
            row_d   = '0;
            count_d = '0;
            state_d = S_WLOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WLOAD: begin
        w_req  = 1'b1;
        w_addr = row_q;
        if (w_valid) begin
          gw_d  = w_data;
          tag_d = row_q;
          vy_d  = 1'b1;
          row_d = row_q + 4'd1;
          if (row_q == 4'(ROWS - 1)) begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        x_ready = 1'b1;
        if (x_valid) begin
          gi_d    = x_data;
          vx_d    = x_mask;
          dl_d[0] = 1'b1;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The newest result is the youngest entry; once nothing sits below
        // the tap, the last psum is on res_valid this cycle.
        if ((dl_q & below_lat) == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      vy_d    = 1'b0;
      vx_d    = '0;
      dl_d    = '0;
      row_d   = '0;
      count_d = '0;
      gw_d    = gw_q;
      tag_d   = tag_q;
      gi_d    = gi_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      lat_q   <= '0;
      dl_q    <= '0;
      gw_q    <= '0;
      tag_q   <= '0;
      vy_q    <= 1'b0;
      gi_q    <= '0;
      vx_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      count_q <= count_d;
      len_q   <= len_d;
      lat_q   <= lat_d;
      dl_q    <= dl_d;
      gw_q    <= gw_d;
      tag_q   <= tag_d;
      vy_q    <= vy_d;
      gi_q    <= gi_d;
      vx_q    <= vx_d;
    end
  end

  assign g_weight  = gw_q;
  assign g_tag_row = tag_q;
  assign g_valid_y = vy_q;
  assign g_image   = gi_q;
  assign g_valid_x = vx_q;
  assign res_valid = dl_q[lat_q];
  assign res_data  = g_psum;

endmodule
